// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the four-port data-memory responder.
//   DATA_W_DEF / ADDR_W_DEF : default word width and internal address width
//   NUM_PORTS               : number of requesting cores
//   state_t                 : responder FSM state (IDLE, ACCESS, RESP)
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int NUM_PORTS  = 4;
    localparam int REQ_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_responder_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
// Four-way round-robin selector. The search starts at the port after the
// last granted one and wraps, so a port just served has lowest priority.
//   req       : request vector, bit i = port i
//   last      : index of the most recently granted port
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : binary index of the granted port (0 when no request)
//   any       : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter4
    import dmem_responder_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           last,
    output logic [NUM_PORTS-1:0] grant,
    output logic [1:0]           grant_idx,
    output logic                 any
);

    logic [1:0] idx;

    always_comb begin
        grant_idx = 2'd0;
        any       = 1'b0;
        idx       = 2'd0;
        // Offsets 1..4 from last; the 2-bit truncation provides the wrap.
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = 2'(int'(last) + k);
            if (!any && req[idx]) begin
                any       = 1'b1;
                grant_idx = idx;
            end
        end
        grant = any ? (4'b0001 << grant_idx) : 4'b0000;
    end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Single-ported word memory shared by four cores. One request is accepted
// at a time through a round-robin arbiter; the response follows exactly two
// cycles after acceptance (IDLE -> ACCESS -> RESP).
//
// Handshake: a core holds req_valid with its fields; in IDLE the granted
// core sees a one-cycle req_ready pulse, and its write/addr/data are latched
// on that same clock edge (the core may drop or change them afterwards).
// Two cycles later resp_valid pulses for one cycle on that core's bit with
// resp_data (read data, or the echoed write data). There is no backpressure
// on the response side.
//
// Ports:
//   main_clock, reset         : clock, synchronous active-high reset
//   req_valid/req_write [3:0] : per-core request and direction (1 = write)
//   req_addr0..3 [15:0]       : word address, low ADDR_W bits used
//   req_data0..3 [DATA_W-1:0] : write data
//   req_ready [3:0]           : one-hot accept pulse
//   resp_valid [3:0]          : one-hot response pulse
//   resp_data                 : response data, held until the next ACCESS
//   grant_id [1:0]            : port currently being serviced
//   busy                      : high in ACCESS and RESP
//   fsm_state                 : current FSM state (observability)
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
)
(
    input  logic                  main_clock,
    input  logic                  reset,
    input  logic [NUM_PORTS-1:0]  req_valid,
    input  logic [NUM_PORTS-1:0]  req_write,
    input  logic [REQ_ADDR_W-1:0] req_addr0,
    input  logic [REQ_ADDR_W-1:0] req_addr1,
    input  logic [REQ_ADDR_W-1:0] req_addr2,
    input  logic [REQ_ADDR_W-1:0] req_addr3,
    input  logic [DATA_W-1:0]     req_data0,
    input  logic [DATA_W-1:0]     req_data1,
    input  logic [DATA_W-1:0]     req_data2,
    input  logic [DATA_W-1:0]     req_data3,
    output logic [NUM_PORTS-1:0]  req_ready,
    output logic [NUM_PORTS-1:0]  resp_valid,
    output logic [DATA_W-1:0]     resp_data,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output state_t                fsm_state
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t                 state;
    state_t                 state_next;
    logic [1:0]             last;
    logic                   accept;

    logic [NUM_PORTS-1:0]   arb_grant;
    logic [1:0]             arb_idx;
    logic                   arb_any;

    logic [REQ_ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]      sel_data;
    logic                   addr_hi_unused;

    logic                   lat_write;
    logic [ADDR_W-1:0]      lat_addr;
    logic [DATA_W-1:0]      lat_data;

    logic [DATA_W-1:0]      mem [DEPTH];

    rr_arbiter4 u_arb (
        .req       (req_valid),
        .last      (last),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Fields of the port the arbiter is choosing this cycle.
    always_comb begin
        sel_addr = req_addr0;
        sel_data = req_data0;
        case (arb_idx)
            2'd1: begin sel_addr = req_addr1; sel_data = req_data1; end
            2'd2: begin sel_addr = req_addr2; sel_data = req_data2; end
            2'd3: begin sel_addr = req_addr3; sel_data = req_data3; end
            default: ;
        endcase
    end

    // Upper address bits are deliberately dropped: addresses wrap mod DEPTH.
    assign addr_hi_unused = ^sel_addr[REQ_ADDR_W-1:ADDR_W];

    always_comb begin
        state_next = state;
        req_ready  = '0;
        resp_valid = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_next = ACCESS;
                    req_ready  = arb_grant;
                    accept     = 1'b1;
                end
            end
            ACCESS: state_next = RESP;
            RESP: begin
                state_next = IDLE;
                resp_valid = 4'b0001 << grant_id;
            end
            default: state_next = IDLE;
        endcase
        // Nothing is accepted or answered while reset is asserted.
        if (reset) begin
            req_ready  = '0;
            resp_valid = '0;
            accept     = 1'b0;
        end
    end

    always_ff @(posedge main_clock) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 2'd3;
            grant_id  <= 2'd0;
            resp_data <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                last      <= arb_idx;
                grant_id  <= arb_idx;
                lat_write <= req_write[arb_idx];
                lat_addr  <= sel_addr[ADDR_W-1:0];
                lat_data  <= sel_data;
            end
            if (state == ACCESS) begin
                resp_data <= lat_write ? lat_data : mem[lat_addr];
            end
        end
    end

    // Storage is never cleared; a reset landing on ACCESS cancels the write.
    always_ff @(posedge main_clock) begin
        if (!reset && state == ACCESS && lat_write) begin
            mem[lat_addr] <= lat_data;
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        main_clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_write;
    logic [15:0] req_addr0, req_addr1, req_addr2, req_addr3;
    logic [15:0] req_data0, req_data1, req_data2, req_data3;
    logic [3:0]  req_ready, resp_valid;
    logic [15:0] resp_data;
    logic [1:0]  grant_id;
    logic        busy;
    state_t      fsm_state;

    dmem_responder #(.DATA_W(16), .ADDR_W(8)) dut (
        .main_clock (main_clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_addr2  (req_addr2),
        .req_addr3  (req_addr3),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_data2  (req_data2),
        .req_data3  (req_data3),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .grant_id   (grant_id),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 main_clock = ~main_clock;

    // ---------------- scoreboard counters ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Transaction view: an accepted request occupies the memory for three
    // cycles (accept, access, respond); the response is due two cycles after
    // acceptance.
    logic [15:0] ref_mem [256];
    int          m_phase;      // cycles since accept: 0 = free, 1, 2
    int          m_last;
    int          m_gid;
    logic [15:0] m_rdata;
    logic        m_wr;
    int          m_addr;
    logic [15:0] m_data;

    function automatic int rr_pick(input logic [3:0] v, input int lst);
        for (int k = 1; k <= 4; k++) begin
            if (v[(lst + k) % 4]) return (lst + k) % 4;
        end
        return lst;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_last  = 3;
        m_gid   = 0;
        m_rdata = 16'h0;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic [3:0] v, input logic [3:0] w,
                        input logic [3:0][15:0] a, input logic [3:0][15:0] d);
        logic [3:0] e_ready, e_rv;
        state_t     e_state;
        int         g;
        @(negedge main_clock);
        reset     = r;
        req_valid = v;
        req_write = w;
        req_addr0 = a[0]; req_addr1 = a[1]; req_addr2 = a[2]; req_addr3 = a[3];
        req_data0 = d[0]; req_data1 = d[1]; req_data2 = d[2]; req_data3 = d[3];
        #1;
        g       = rr_pick(v, m_last);
        e_ready = (!r && m_phase == 0 && v != 4'h0) ? (4'b0001 << g) : 4'h0;
        e_rv    = (!r && m_phase == 2) ? (4'b0001 << m_gid) : 4'h0;
        e_state = (m_phase == 0) ? IDLE : (m_phase == 1) ? ACCESS : RESP;
        check("req_ready",  32'(req_ready),  32'(e_ready));
        check("resp_valid", 32'(resp_valid), 32'(e_rv));
        check("resp_data",  32'(resp_data),  32'(m_rdata));
        check("grant_id",   32'(grant_id),   32'(m_gid));
        check("busy",       32'(busy),       32'(m_phase != 0));
        check("fsm_state",  32'(fsm_state),  32'(e_state));
        // advance model across the coming edge
        if (r) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (v != 4'h0) begin
                m_wr    = w[g];
                m_addr  = int'(a[g]) % 256;
                m_data  = d[g];
                m_gid   = g;
                m_last  = g;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_wr) begin
                ref_mem[m_addr] = m_data;
                m_rdata = m_data;
            end else begin
                m_rdata = ref_mem[m_addr];
            end
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic step1(input logic r, input logic [3:0] v, input logic [3:0] w,
                         input logic [15:0] a, input logic [15:0] d);
        step(r, v, w, {4{a}}, {4{d}});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  w;
        logic [15:0] a;
        logic [15:0] d;
        logic [3:0]  e_ready;
        logic [3:0]  e_rv;
        logic [15:0] e_rdata;
        logic [1:0]  e_gid;
        logic        e_busy;
    } vec_t;

    vec_t tbl [25];

    // ---------------- test ----------------
    initial begin : test
        int          grants_since_join;
        int          prev_g;
        bit          joined;
        bit          seen0;
        logic [3:0][15:0] ra, rd;

        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;

        // write addr 5, read it back; then reset and four-way contention
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 16'h0005, 16'h0000, 4'h0, 4'h0, 16'h0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'h1, 4'h1, 16'h0005, 16'h1234, 4'h1, 4'h0, 16'h0000, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 16'h0000, 2'd0, 1'b1};
        tbl[3]  = '{1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h1, 16'h1234, 2'd0, 1'b1};
        tbl[4]  = '{1'b0, 4'h1, 4'h0, 16'h0005, 16'h0000, 4'h1, 4'h0, 16'h1234, 2'd0, 1'b0};
        tbl[5]  = '{1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 16'h1234, 2'd0, 1'b1};
        tbl[6]  = '{1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h1, 16'h1234, 2'd0, 1'b1};
        tbl[7]  = '{1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 16'h1234, 2'd0, 1'b0};
        tbl[8]  = '{1'b1, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 16'h1234, 2'd0, 1'b0};
        tbl[9]  = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h1, 4'h0, 16'h0000, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h0, 4'h0, 16'h0000, 2'd0, 1'b1};
        tbl[11] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h0, 4'h1, 16'h1234, 2'd0, 1'b1};
        tbl[12] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h2, 4'h0, 16'h1234, 2'd0, 1'b0};
        tbl[13] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h0, 4'h0, 16'h1234, 2'd1, 1'b1};
        tbl[14] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h0, 4'h2, 16'h1234, 2'd1, 1'b1};
        tbl[15] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h4, 4'h0, 16'h1234, 2'd1, 1'b0};
        tbl[16] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h0, 4'h0, 16'h1234, 2'd2, 1'b1};
        tbl[17] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h0, 4'h4, 16'h1234, 2'd2, 1'b1};
        tbl[18] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h8, 4'h0, 16'h1234, 2'd2, 1'b0};
        tbl[19] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h0, 4'h0, 16'h1234, 2'd3, 1'b1};
        tbl[20] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h0, 4'h8, 16'h1234, 2'd3, 1'b1};
        tbl[21] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h1, 4'h0, 16'h1234, 2'd3, 1'b0};
        tbl[22] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h0, 4'h0, 16'h1234, 2'd0, 1'b1};
        tbl[23] = '{1'b0, 4'hF, 4'h0, 16'h0005, 16'h0000, 4'h0, 4'h1, 16'h1234, 2'd0, 1'b1};
        tbl[24] = '{1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 16'h1234, 2'd0, 1'b0};

        // ---- initial reset ----
        reset = 1'b1; req_valid = 4'h0; req_write = 4'h0;
        req_addr0 = '0; req_addr1 = '0; req_addr2 = '0; req_addr3 = '0;
        req_data0 = '0; req_data1 = '0; req_data2 = '0; req_data3 = '0;
        repeat (2) @(posedge main_clock);
        model_reset();

        // ---- table ----
        for (int i = 0; i < 25; i++) begin
            step1(tbl[i].rst, tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d);
            check($sformatf("tbl%0d_ready", i),   32'(req_ready),  32'(tbl[i].e_ready));
            check($sformatf("tbl%0d_rvalid", i),  32'(resp_valid), 32'(tbl[i].e_rv));
            check($sformatf("tbl%0d_rdata", i),   32'(resp_data),  32'(tbl[i].e_rdata));
            check($sformatf("tbl%0d_gid", i),     32'(grant_id),   32'(tbl[i].e_gid));
            check($sformatf("tbl%0d_busy", i),    32'(busy),       32'(tbl[i].e_busy));
        end

        // ---- address wrap: core2 writes 0x0103, core1 reads 0x0003 ----
        step1(1'b1, 4'h0, 4'h0, 16'h0, 16'h0);
        step1(1'b0, 4'h4, 4'h4, 16'h0103, 16'hBEEF);
        check("wrap_wr_ready", 32'(req_ready), 32'h4);
        step1(1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        step1(1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        step1(1'b0, 4'h2, 4'h0, 16'h0003, 16'h0);
        check("wrap_rd_ready", 32'(req_ready), 32'h2);
        step1(1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        step1(1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        check("wrap_rvalid", 32'(resp_valid), 32'h2);
        check("wrap_rdata",  32'(resp_data),  32'hBEEF);

        // ---- reset during ACCESS cancels the write ----
        step1(1'b1, 4'h0, 4'h0, 16'h0, 16'h0);
        step1(1'b0, 4'h1, 4'h1, 16'h0007, 16'hAAAA);
        step1(1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        step1(1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        step1(1'b0, 4'h2, 4'h2, 16'h0007, 16'h5555);
        check("rst_acc_ready", 32'(req_ready), 32'h2);
        step1(1'b1, 4'h0, 4'h0, 16'h0, 16'h0);
        step1(1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        check("rst_acc_rvalid", 32'(resp_valid), 32'h0);
        check("rst_acc_busy",   32'(busy),       32'h0);
        check("rst_acc_gid",    32'(grant_id),   32'h0);
        step1(1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        check("rst_acc_rvalid2", 32'(resp_valid), 32'h0);
        step1(1'b0, 4'h1, 4'h0, 16'h0007, 16'h0);
        step1(1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        step1(1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        check("rst_acc_rd_rvalid", 32'(resp_valid), 32'h1);
        check("rst_acc_rd_rdata",  32'(resp_data),  32'hAAAA);

        // ---- core3 drops request and changes address after accept ----
        step1(1'b1, 4'h0, 4'h0, 16'h0, 16'h0);
        step1(1'b0, 4'h8, 4'h0, 16'h0007, 16'h0);
        check("drop_ready", 32'(req_ready), 32'h8);
        step1(1'b0, 4'h0, 4'h0, 16'h0020, 16'h0);
        step1(1'b0, 4'h0, 4'h8, 16'h0020, 16'h0);
        check("drop_rvalid", 32'(resp_valid), 32'h8);
        check("drop_rdata",  32'(resp_data),  32'hAAAA);

        // ---- fairness: cores 1 and 3 continuous, core 0 joins ----
        step1(1'b1, 4'h0, 4'h0, 16'h0, 16'h0);
        prev_g = -1; joined = 0; seen0 = 0; grants_since_join = 0;
        for (int c = 0; c < 36; c++) begin
            if (c == 12) joined = 1;
            step1(1'b0, joined ? 4'hB : 4'hA, 4'h0, 16'h0007, 16'h0);
            if (req_ready != 4'h0) begin
                int g;
                g = (req_ready == 4'h1) ? 0 : (req_ready == 4'h2) ? 1 :
                    (req_ready == 4'h4) ? 2 : 3;
                if (prev_g >= 0) check("fair_no_repeat", 32'(g == prev_g), 32'h0);
                prev_g = g;
                if (joined && !seen0) begin
                    grants_since_join++;
                    if (g == 0) seen0 = 1;
                end
            end
        end
        check("fair_core0_served", 32'(seen0), 32'h1);
        check("fair_core0_within2", 32'(grants_since_join <= 2), 32'h1);
        repeat (3) step1(1'b0, 4'h0, 4'h0, 16'h0, 16'h0);

        // ---- preload every location so random reads have known values ----
        for (int i = 0; i < 256; i++) begin
            step1(1'b0, 4'h1, 4'h1, 16'(i), 16'($urandom));
            step1(1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
            step1(1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        end

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 4; p++) begin
                ra[p] = 16'($urandom);
                rd[p] = 16'($urandom);
            end
            step($urandom_range(0, 39) == 0, 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), ra, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
